commutator_2_2: RTL and testbench
=================================

Name: commutator_2_2

Overview:
- Two-lane streaming delay-commutator for the NTT datapath: delay line, registered 2x2 swap, delay line.
- Performs a 2x2 block transpose on DEPTH-beat blocks. Input block pairs (A_k,B_k),(A_{k+1},B_{k+1}) leave as (A_k,A_{k+1}),(B_k,B_{k+1}).
- Sits between butterfly stages. Cascading instances with DEPTH = N/4, N/8, … builds the stride permutations between stages.
- Extends the fixed-control registered 2x2 switch with self-generated control, parametrised block depth, valid-gated stalling and pipeline priming.

Parameters:
- DATA_WIDTH, 28, width of one coefficient lane.
- DEPTH, 8, block length in beats; power of two, 1 to 512.
- CNT_W, $clog2(DEPTH)+1, beat-counter width (derived; not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- inData_0  input  DATA_WIDTH  lane-0 input coefficient
- inData_1  input  DATA_WIDTH  lane-1 input coefficient
- in_valid  input  1  input beat valid; the whole pipeline advances only on in_valid=1
- outData_0  output  DATA_WIDTH  lane-0 output, registered
- outData_1  output  DATA_WIDTH  lane-1 output, registered
- out_valid  output  1  output beat valid, registered
- ctrl_dbg  output  1  current swap control, for bench visibility

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: outData_0=0, outData_1=0, out_valid=0, beat counter=0, prime counter=0, ctrl_dbg=0. Delay-line contents are don't-care, masked by priming.
- Beat index: n counts accepted beats (in_valid=1) since reset. Input block k = floor(n/DEPTH).
- Beat counter: CNT_W bits, wraps modulo 2*DEPTH. Swap control ctrl = counter[CNT_W-1], i.e. ctrl=1 for odd k.
- Datapath, applied per accepted beat:
  - lane 1 passes through a DEPTH-beat delay line, giving d1;
  - swap: s0 = ctrl ? d1 : inData_0, s1 = ctrl ? inData_0 : d1;
  - s0 passes through a DEPTH-beat delay line, giving outData_0;
  - s1 goes directly to outData_1.
- Delay lines shift only on in_valid=1. With in_valid=0 everything holds, so bubbles anywhere in the stream do not change the output sequence.
- Priming: the prime counter saturates at DEPTH.
  - out_valid <= in_valid && (prime==DEPTH), evaluated before that beat's increment.
  - outData_* load only when that condition holds; otherwise they hold their value.
- Latency: output beat m=n-DEPTH appears the cycle after input beat n. The first out_valid comes the cycle after beat n=DEPTH.
- Output mapping, with j=floor(m/DEPTH) and i=m mod DEPTH:
  - j even: out0 = A_j[i], out1 = A_{j+1}[i];
  - j odd: out0 = B_{j-1}[i], out1 = B_j[i].
- DEPTH=1: ctrl alternates every beat, and both delay lines are single registers.
- Counter wrap: 2*DEPTH-1 → 0, seamless. No gap in the output stream.
- Reset mid-stream: everything returns to reset values on the next edge, and priming restarts. Reset wins over a simultaneous in_valid.
- No backpressure; downstream must accept every out_valid beat.
- Widths: pure data movement, no arithmetic. Lanes keep DATA_WIDTH bits throughout.

Decomposition:
- Package ntt_stream_pkg:
  - typedef coeff_t as logic [DATA_WIDTH-1:0];
  - function is_pow2 for an elaboration assertion on DEPTH.
- Sub-module delay_line_en (params DATA_WIDTH, DEPTH; ports clk, en, din, dout): shift register advancing on en, no reset. Instantiated twice.
- Control counter, swap and output registers live in commutator_2_2.

Test Plan:
- DEPTH=2, continuous valid, lane0 = 0,1,2,…, lane1 = 100,101,….
  - out_valid rises the cycle after the 3rd beat.
  - Pairs are (0,2),(1,3),(100,102),(101,103),(4,6),(5,7),(104,106),(105,107).
- Same stimulus with in_valid deasserted every 3rd cycle → identical pair sequence; out_valid low exactly on the cycles following the bubbles.
- DEPTH=1, lane0 = 0,1,2,3, lane1 = 10,11,12,13 → pairs (0,1),(10,11),(2,3),…; ctrl_dbg toggles every beat.
- DEPTH=8, 64 beats of random data vs. a transpose reference model → all 56 outputs match; counter wraps seamlessly every 16 beats.
- Assert rst at beat 5 of a DEPTH=4 stream.
  - Next cycle: outputs 0, out_valid 0.
  - Restart lane0 = 0…, lane1 = 100… → first valid output (0,4) the cycle after the 5th post-reset beat.
- rst and in_valid high in the same cycle → reset state wins; that beat is not counted.

Source files
------------

// File: rtl/ntt_stream_pkg.sv
// Shared types and elaboration helpers for the two-lane NTT streaming datapath.
package ntt_stream_pkg;

   localparam int COEFF_W = 28;

   typedef logic [COEFF_W-1:0] coeff_t;

   function automatic bit is_pow2(input int value);
      return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
   endfunction

endpackage

// File: rtl/delay_line_en.sv
// Enable-gated shift register: dout is the din accepted DEPTH enabled cycles ago.
module delay_line_en
   import ntt_stream_pkg::*;
#(
   parameter int DATA_WIDTH = COEFF_W,
   parameter int DEPTH      = 8
)(
   input  logic                  clk,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] stage_r [DEPTH];

   // Shift one position per enabled cycle; contents need no reset because priming masks them.
   always_ff @(posedge clk) begin
      if (en) begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/commutator_2_2.sv
// Two-lane delay commutator: delay line on lane 1, registered 2x2 swap, delay line on lane 0.
// Transposes 2x2 groups of DEPTH-beat blocks; the whole pipeline stalls while in_valid is low.
module commutator_2_2
   import ntt_stream_pkg::*;
#(
   parameter int DATA_WIDTH = COEFF_W,
   parameter int DEPTH      = 8,
   localparam int CNT_W     = $clog2(DEPTH) + 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] inData_0,
   input  logic [DATA_WIDTH-1:0] inData_1,
   input  logic                  in_valid,
   output logic [DATA_WIDTH-1:0] outData_0,
   output logic [DATA_WIDTH-1:0] outData_1,
   output logic                  out_valid,
   output logic                  ctrl_dbg
);

   localparam logic [CNT_W-1:0] PRIME_MAX = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

   if (!is_pow2(DEPTH) || (DEPTH > 32'sd512)) begin : g_depth_check
      $error("commutator_2_2: DEPTH must be a power of two in 1..512");
   end

   logic [CNT_W-1:0]      beat_cnt_r;
   logic [CNT_W-1:0]      prime_cnt_r;
   logic                  ctrl_s;
   logic                  primed_s;
   logic                  shift_en_s;
   logic                  load_s;
   logic [DATA_WIDTH-1:0] d1_s;
   logic [DATA_WIDTH-1:0] d0_s;
   logic [DATA_WIDTH-1:0] s0_s;
   logic [DATA_WIDTH-1:0] s1_s;

   // Counter MSB flips every DEPTH accepted beats: high while an odd input block is arriving.
   assign ctrl_s     = beat_cnt_r[CNT_W-1];
   assign ctrl_dbg   = ctrl_s;
   assign primed_s   = (prime_cnt_r == PRIME_MAX);
   assign shift_en_s = in_valid && !rst;
   assign load_s     = in_valid && primed_s;

   delay_line_en #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_delay_lane1 (
      .clk  (clk),
      .en   (shift_en_s),
      .din  (inData_1),
      .dout (d1_s)
   );

   // 2x2 swap between the current lane-0 beat and the delayed lane-1 beat.
   always_comb begin
      s0_s = inData_0;
      s1_s = d1_s;
      if (ctrl_s) begin
         s0_s = d1_s;
         s1_s = inData_0;
      end else begin
         s0_s = inData_0;
         s1_s = d1_s;
      end
   end

   delay_line_en #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_delay_lane0 (
      .clk  (clk),
      .en   (shift_en_s),
      .din  (s0_s),
      .dout (d0_s)
   );

   // Beat counter wraps naturally at 2*DEPTH; prime counter saturates once the delay lines are full.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_r  <= '0;
         prime_cnt_r <= '0;
      end else if (in_valid) begin
         beat_cnt_r <= beat_cnt_r + CNT_ONE;
         if (!primed_s) begin
            prime_cnt_r <= prime_cnt_r + CNT_ONE;
         end
      end
   end

   // Output registers load only on primed accepted beats and hold through bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         outData_0 <= '0;
         outData_1 <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= load_s;
         if (load_s) begin
            outData_0 <= d0_s;
            outData_1 <= s1_s;
         end
      end
   end

endmodule

// File: tb/tb_commutator_2_2.sv
// Self-checking bench: four instances (DEPTH 1,2,4,8) share one stimulus stream and are
// checked against a block-transpose reference through a scoreboard queue.
module tb_commutator_2_2;

   localparam int DW = 28;
   localparam int NI = 4;

   typedef struct {
      int          inst;
      logic [DW-1:0] o0;
      logic [DW-1:0] o1;
   } exp_t;

   typedef struct {
      bit          v;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      bit          v1;
      logic [DW-1:0] e1_0;
      logic [DW-1:0] e1_1;
      bit          v2;
      logic [DW-1:0] e2_0;
      logic [DW-1:0] e2_1;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in0 = '0;
   logic [DW-1:0] in1 = '0;
   logic [DW-1:0] o0 [NI];
   logic [DW-1:0] o1 [NI];
   logic          ov [NI];
   logic          cd [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      commutator_2_2 #(
         .DATA_WIDTH (DW),
         .DEPTH      (1 << g)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .inData_0  (in0),
         .inData_1  (in1),
         .in_valid  (in_valid),
         .outData_0 (o0[g]),
         .outData_1 (o1[g]),
         .out_valid (ov[g]),
         .ctrl_dbg  (cd[g])
      );
   end

   int            checks = 0;
   int            errors = 0;
   int            n = 0;
   logic [DW-1:0] h0 [2048];
   logic [DW-1:0] h1 [2048];
   bit            exp_v [NI];
   bit            ectrl [NI];
   logic [DW-1:0] eo0 [NI];
   logic [DW-1:0] eo1 [NI];
   exp_t          sb_q [$];
   vec_t          vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: output beat m = n-D, block j = m/D; even j -> (A_j, A_j+1), odd j -> (B_j-1, B_j).
   task automatic model_update(input bit r, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (r) begin
         n = 0;
         sb_q.delete();
         for (int g = 0; g < NI; g++) begin
            exp_v[g] = 1'b0; ectrl[g] = 1'b0; eo0[g] = '0; eo1[g] = '0;
         end
      end else if (v) begin
         h0[n] = a;
         h1[n] = b;
         for (int g = 0; g < NI; g++) begin
            int d, m, j;
            exp_t e;
            d = 1 << g;
            if (n >= d) begin
               m = n - d;
               j = m / d;
               e.inst = g;
               if ((j % 2) == 0) begin
                  e.o0 = h0[m]; e.o1 = h0[m + d];
               end else begin
                  e.o0 = h1[m - d]; e.o1 = h1[m];
               end
               sb_q.push_back(e);
               exp_v[g] = 1'b1;
            end else begin
               exp_v[g] = 1'b0;
            end
            ectrl[g] = (((n + 1) / d) % 2) == 1;
         end
         n++;
      end else begin
         for (int g = 0; g < NI; g++) exp_v[g] = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int g = 0; g < NI; g++) begin
         string tag;
         exp_t  e;
         tag = $sformatf("d%0d", 1 << g);
         chk({tag, "_out_valid"}, 32'(ov[g]), 32'(exp_v[g]));
         chk({tag, "_ctrl_dbg"}, 32'(cd[g]), 32'(ectrl[g]));
         if (ov[g] === 1'b1) begin
            if (sb_q.size() > 0 && sb_q[0].inst == g) begin
               e = sb_q.pop_front();
               eo0[g] = e.o0;
               eo1[g] = e.o1;
            end else begin
               checks++;
               errors++;
               $display("FAIL %s_scoreboard actual=unexpected_output required=no_output", tag);
            end
         end
         chk({tag, "_out0"}, 32'(o0[g]), 32'(eo0[g]));
         chk({tag, "_out1"}, 32'(o1[g]), 32'(eo1[g]));
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b);
      rst = r; in_valid = v; in0 = a; in1 = b;
      model_update(r, v, a, b);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int acc;
      int v8cnt;
      vec[0] = '{1'b1, 28'd0, 28'd100, 1'b0, 28'd0,   28'd0,   1'b0, 28'd0,   28'd0};
      vec[1] = '{1'b1, 28'd1, 28'd101, 1'b1, 28'd0,   28'd1,   1'b0, 28'd0,   28'd0};
      vec[2] = '{1'b1, 28'd2, 28'd102, 1'b1, 28'd100, 28'd101, 1'b1, 28'd0,   28'd2};
      vec[3] = '{1'b1, 28'd3, 28'd103, 1'b1, 28'd2,   28'd3,   1'b1, 28'd1,   28'd3};
      vec[4] = '{1'b1, 28'd4, 28'd104, 1'b1, 28'd102, 28'd103, 1'b1, 28'd100, 28'd102};
      vec[5] = '{1'b1, 28'd5, 28'd105, 1'b1, 28'd4,   28'd5,   1'b1, 28'd101, 28'd103};
      vec[6] = '{1'b1, 28'd6, 28'd106, 1'b1, 28'd104, 28'd105, 1'b1, 28'd4,   28'd6};
      vec[7] = '{1'b1, 28'd7, 28'd107, 1'b1, 28'd6,   28'd7,   1'b1, 28'd5,   28'd7};
      vec[8] = '{1'b1, 28'd8, 28'd108, 1'b1, 28'd106, 28'd107, 1'b1, 28'd104, 28'd106};
      vec[9] = '{1'b1, 28'd9, 28'd109, 1'b1, 28'd8,   28'd9,   1'b1, 28'd105, 28'd107};

      // Reset state
      step(1'b1, 1'b0, '0, '0);
      step(1'b1, 1'b0, '0, '0);

      // Continuous stream, hand-derived pairs for DEPTH 1 and 2
      for (int t = 0; t < 10; t++) begin
         step(1'b0, vec[t].v, vec[t].a, vec[t].b);
         chk($sformatf("tbl%0d_d1_valid", t), 32'(ov[0]), 32'(vec[t].v1));
         chk($sformatf("tbl%0d_d2_valid", t), 32'(ov[1]), 32'(vec[t].v2));
         if (vec[t].v1) begin
            chk($sformatf("tbl%0d_d1_out0", t), 32'(o0[0]), 32'(vec[t].e1_0));
            chk($sformatf("tbl%0d_d1_out1", t), 32'(o1[0]), 32'(vec[t].e1_1));
         end
         if (vec[t].v2) begin
            chk($sformatf("tbl%0d_d2_out0", t), 32'(o0[1]), 32'(vec[t].e2_0));
            chk($sformatf("tbl%0d_d2_out1", t), 32'(o1[1]), 32'(vec[t].e2_1));
         end
      end

      // Same stream with a bubble every third cycle
      step(1'b1, 1'b0, '0, '0);
      acc = 0;
      for (int c = 0; c < 30; c++) begin
         if ((c % 3) == 2) begin
            step(1'b0, 1'b0, 28'd999, 28'd999);
         end else begin
            step(1'b0, 1'b1, 28'(acc), 28'(100 + acc));
            acc++;
         end
      end

      // Reset and in_valid together: the beat must not be counted
      step(1'b1, 1'b1, 28'd77, 28'd88);
      step(1'b0, 1'b1, 28'd0, 28'd100);
      chk("rst_wins_d1_ctrl", 32'(cd[0]), 32'd1);
      chk("rst_wins_d1_valid", 32'(ov[0]), 32'd0);

      // Reset in the middle of a DEPTH=4 stream, then restart
      step(1'b1, 1'b0, '0, '0);
      for (int t = 0; t < 5; t++) step(1'b0, 1'b1, 28'(t + 50), 28'(t + 150));
      step(1'b1, 1'b1, 28'd55, 28'd155);
      chk("midrst_d4_valid", 32'(ov[2]), 32'd0);
      chk("midrst_d4_out0", 32'(o0[2]), 32'd0);
      chk("midrst_d4_out1", 32'(o1[2]), 32'd0);
      for (int t = 0; t < 5; t++) step(1'b0, 1'b1, 28'(t), 28'(100 + t));
      chk("restart_d4_valid", 32'(ov[2]), 32'd1);
      chk("restart_d4_out0", 32'(o0[2]), 32'd0);
      chk("restart_d4_out1", 32'(o1[2]), 32'd4);

      // 64 random beats: DEPTH=8 must produce exactly 56 outputs
      step(1'b1, 1'b0, '0, '0);
      v8cnt = 0;
      for (int t = 0; t < 64; t++) begin
         step(1'b0, 1'b1, 28'($urandom()), 28'($urandom()));
         if (ov[3] === 1'b1) v8cnt++;
      end
      chk("rand_d8_count", 32'(v8cnt), 32'd56);

      // Random data with random bubbles
      for (int t = 0; t < 120; t++) begin
         step(1'b0, ($urandom_range(0, 3) != 0), 28'($urandom()), 28'($urandom()));
      end
      step(1'b0, 1'b0, '0, '0);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
